// File: rtl/clk_div_tick.sv
// Synchronous programmable clock divider producing a one-cycle tick (clock enable)
// and a near-50% registered square wave, with count enable and one-shot mode.
module clk_div_tick #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  input  logic             oneshot,
  output logic             tick,
  output logic             clk_out,
  output logic             armed,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_step;
  logic             tick_reg, tick_next;
  logic             clk_out_reg, clk_out_next;
  logic             armed_reg, armed_next;
  logic             run;
  logic             wrap;

  always_comb begin
    run      = en & armed_reg & ~load;
    // >= rather than == so a counter left above the divisor wraps immediately
    wrap     = (cnt_reg >= (div_reg - ONE));
    cnt_step = wrap ? '0 : (cnt_reg + ONE);

    div_next     = div_reg;
    cnt_next     = cnt_reg;
    tick_next    = 1'b0;
    clk_out_next = clk_out_reg;
    armed_next   = armed_reg;

    if (load) begin
      div_next     = (div_val < DIV_MIN) ? DIV_MIN : div_val;
      cnt_next     = '0;
      clk_out_next = 1'b0;
      armed_next   = 1'b1;
    end else if (run) begin
      cnt_next     = cnt_step;
      tick_next    = wrap;
      clk_out_next = (cnt_step >= (div_reg >> 1));
      if (wrap && oneshot) begin
        armed_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg     <= DIV_RST;
      cnt_reg     <= '0;
      tick_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      div_reg     <= div_next;
      cnt_reg     <= cnt_next;
      tick_reg    <= tick_next;
      clk_out_reg <= clk_out_next;
      armed_reg   <= armed_next;
    end
  end

  assign tick    = tick_reg;
  assign clk_out = clk_out_reg;
  assign armed   = armed_reg;
  assign count   = cnt_reg;

endmodule

// File: doc/clk_div_tick.md
Name: clk_div_tick

Overview:
- Fully synchronous, parametrised clock divider that replaces ripple toggle-flop divider chains.
- Produces two outputs from a single system clock:
  - a one-cycle tick, used as a clock enable;
  - a near-50% square wave.
- The divide ratio is programmable at run time. An enable input gates counting, and a one-shot mode is available.
- Sits between the board clock and slow logic such as second counters, LED blinkers and display scan.

Parameters:
- CNT_W, 27: width of the internal counter and of the divisor register.
- DEFAULT_DIV, 100_000_000: divisor after reset. Must satisfy 2 <= DEFAULT_DIV < 2**CNT_W. At 100 MHz this gives 1 Hz.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable. When low, the counter holds.
- load  in  1  single-cycle strobe. Captures div_val, restarts the counter and re-arms the block.
- div_val  in  CNT_W  new divisor, sampled only on load.
- oneshot  in  1  when 1, the block stops after the next wrap until the next load.
- tick  out  1  one-cycle pulse, once per period.
- clk_out  out  1  registered square wave.
- armed  out  1  1 while the block is able to count.
- count  out  CNT_W  current counter value.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - On a clk edge with reset=1: div_q=DEFAULT_DIV, cnt=0, tick=0, clk_out=0, armed=1.
  - Reset takes precedence over every other input, including mid-period and during a load.
- Divisor register div_q:
  - On load=1, div_q <= max(div_val, 2). Values 0 and 1 are clamped to 2.
  - div_val is ignored at all other times.
- Priority (highest first): reset, then load, then the counting step.
- Load cycle:
  - cnt <= 0, clk_out <= 0, tick <= 0, armed <= 1.
  - This happens regardless of en.
  - The new div_q applies from the first counting step after the load.
- Counting step:
  - Define run = en & armed & ~load.
  - If run=0: cnt, clk_out and armed hold, and tick <= 0.
  - If run=1:
    - wrap = (cnt == div_q-1).
    - cnt_next = wrap ? 0 : cnt+1.
    - cnt <= cnt_next.
    - tick <= wrap. tick is asserted in the same cycle that cnt returns to 0, and is high for exactly 1 clk.
    - clk_out <= (cnt_next >= (div_q >> 1)).
    - If wrap and oneshot=1: armed <= 0.
- Resulting waveform:
  - Period is div_q clks.
  - clk_out is low for floor(div_q/2) clks and high for ceil(div_q/2) clks.
  - The falling edge of clk_out coincides with tick.
- Latency: the first tick after a reset or load (with en held at 1) is seen div_q cycles after that edge.
- Terminal hold: in one-shot mode, after the wrap, cnt=0 and clk_out=0 hold, and no further ticks occur until load.
- oneshot may change at any time. It is only evaluated on the wrap cycle.
- Guard for a stale counter: if cnt > div_q-1 (only reachable via stale state), the wrap comparison uses >=, so the counter wraps on the next run cycle.
- count output = cnt register. All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

Test Plan:
- Bench parameters: CNT_W=8, DEFAULT_DIV=10. Hold reset for 2 clks, then en=1 -> tick pulses one cycle every 10 clks, with the first tick 10 clks after reset release. clk_out is low for 5 and high for 5, falling edge aligned with tick. armed=1 throughout.
- en=0 for 7 clks in the middle of a period (cnt=4) -> cnt stays at 4, no tick, clk_out unchanged. After en returns to 1, the next tick arrives 6 clks later.
- load with div_val=3 while cnt=7 -> the next cycle shows cnt=0 and clk_out=0. Ticks then come every 3 clks, with clk_out low 1 clk and high 2 clks. A subsequent load with div_val=0 or 1 -> period of 2, clk_out toggles every clk.
- oneshot=1, load with div_val=5 -> exactly one tick, 5 clks after the load. armed falls in the same cycle as the tick. No further ticks for 20 clks. A new load re-arms the block and the next tick follows 5 clks later.
- reset asserted together with load (div_val=4) and en=1 -> div_q=10 and all outputs at their reset values. The next tick arrives 10 clks after reset release.
- Stress: random en and load (div_val in 0..255) over 10k clks, compared against a reference model -> every tick is exactly 1 clk wide, the tick spacing equals div_q whenever en is held high, and count never reaches div_q.
